// File: rtl/host_reg_slave.sv
// Host register bus responder: configuration register file, PROM write
// strobes and the CPU statistics-read apply/grant handshake.
module host_reg_slave #(
    parameter int NUM_REGS   = 35,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                    clk_reg,
    input  logic                    reset,
    input  logic                    csb,
    input  logic                    wrb,
    input  logic [7:0]              ca,
    input  logic [15:0]             cd_in,
    output logic [15:0]             cd_out,
    output logic [NUM_REGS*16-1:0]  cfg_q,
    output logic                    tx_prom_wr,
    output logic                    rx_prom_wr,
    output logic                    CPU_rd_apply,
    input  logic                    CPU_rd_grant,
    input  logic [31:0]             CPU_rd_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } rd_state_e;

    localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] view   [NUM_REGS];
    logic        csb_d_q;
    logic        tx_prom_q;
    logic        rx_prom_q;
    logic        apply_q;
    logic [7:0]  cnt_q;
    rd_state_e   state_q;

    logic [6:0]  idx;
    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        wr29_set;
    logic        wr29_clr;
    logic        rd32;

    function automatic logic [15:0] rst_val(input int i);
        case (i)
            0:       return 16'h001e;
            1:       return 16'h0019;
            3:       return 16'h000f;
            4:       return 16'h001e;
            5:       return 16'h0001;
            6:       return 16'h0002;
            22:      return 16'h001a;
            23:      return 16'h0010;
            24:      return 16'h0001;
            25:      return 16'h000c;
            26:      return 16'h2710;
            27:      return 16'h0040;
            34:      return 16'h0004;
            default: return 16'h0000;
        endcase
    endfunction

    // 10/17 only strobe the PROMs, 29 is the apply control, 30..32 are status
    function automatic logic writable(input int i);
        return !(i == 10 || i == 17 || (i >= 29 && i <= 32));
    endfunction

    assign idx      = ca[7:1];
    assign acc      = ~csb & csb_d_q;
    assign wr_acc   = acc & ~wrb;
    assign rd_acc   = acc & wrb;
    assign wr29_set = wr_acc && idx == 7'd29 && cd_in[0];
    assign wr29_clr = wr_acc && idx == 7'd29 && !cd_in[0];
    assign rd32     = rd_acc && idx == 7'd32;

    always_ff @(posedge clk_reg or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= rst_val(i);
            end
            csb_d_q   <= 1'b1;
            tx_prom_q <= 1'b0;
            rx_prom_q <= 1'b0;
            apply_q   <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= S_IDLE;
        end else begin
            csb_d_q   <= csb;
            tx_prom_q <= wr_acc && idx == 7'd10;
            rx_prom_q <= wr_acc && idx == 7'd17;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_acc && idx == 7'(i) && writable(i)) begin
                    regs_q[i] <= cd_in;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (wr29_set) begin
                        apply_q <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // grant outranks timeout, which outranks a host abort
                    if (CPU_rd_grant) begin
                        regs_q[31] <= CPU_rd_dout[15:0];
                        regs_q[32] <= CPU_rd_dout[31:16];
                        regs_q[30] <= 16'h0001;
                        apply_q    <= 1'b0;
                        state_q    <= S_DONE;
                    end else if (cnt_q == TMO) begin
                        regs_q[31] <= 16'hffff;
                        regs_q[32] <= 16'hffff;
                        regs_q[30] <= 16'h0002;
                        apply_q    <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        if (cnt_q != 8'hff) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        if (wr29_clr) begin
                            apply_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (rd32) begin
                        regs_q[30] <= 16'h0000;
                        state_q    <= S_IDLE;
                    end else if (wr29_set) begin
                        regs_q[30] <= 16'h0000;
                        apply_q    <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            view[i] = regs_q[i];
        end
        view[29] = {15'b0, apply_q};
    end

    always_comb begin
        cd_out = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 7'(i)) begin
                cd_out = view[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_q[16*g +: 16] = view[g];
    end

    assign tx_prom_wr   = tx_prom_q;
    assign rx_prom_wr   = rx_prom_q;
    assign CPU_rd_apply = apply_q;

    logic unused_ok;
    assign unused_ok = ^{ca[0], regs_q[29]};

endmodule

// File: tb/tb_host_reg_slave.sv
// Directed and randomized checks of host_reg_slave against a register model.
module tb_host_reg_slave;

    localparam int N = 35;

    logic            clk = 0;
    logic            reset;
    logic            csb;
    logic            wrb;
    logic [7:0]      ca;
    logic [15:0]     cd_in;
    logic [15:0]     cd_out;
    logic [N*16-1:0] cfg_q;
    logic            tx_prom_wr;
    logic            rx_prom_wr;
    logic            apply;
    logic            grant;
    logic [31:0]     dout;

    int checks = 0;
    int errors = 0;

    logic [15:0]     m [N];
    logic [N*16-1:0] mpack;

    host_reg_slave #(.NUM_REGS(N), .RD_TIMEOUT(255)) dut (
        .clk_reg      (clk),
        .reset        (reset),
        .csb          (csb),
        .wrb          (wrb),
        .ca           (ca),
        .cd_in        (cd_in),
        .cd_out       (cd_out),
        .cfg_q        (cfg_q),
        .tx_prom_wr   (tx_prom_wr),
        .rx_prom_wr   (rx_prom_wr),
        .CPU_rd_apply (apply),
        .CPU_rd_grant (grant),
        .CPU_rd_dout  (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input int i);
        case (i)
            0: return 16'h001e;  1: return 16'h0019;  3: return 16'h000f;
            4: return 16'h001e;  5: return 16'h0001;  6: return 16'h0002;
            22: return 16'h001a; 23: return 16'h0010; 24: return 16'h0001;
            25: return 16'h000c; 26: return 16'h2710; 27: return 16'h0040;
            34: return 16'h0004;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input int idx, input logic [15:0] exp);
        ca = 8'(idx * 2);
        #1;
        chk(tag, {16'h0, cd_out}, {16'h0, exp});
    endtask

    // one access edge; returns at the negedge right after it
    task automatic do_acc(input bit wr, input int idx, input logic [15:0] d);
        csb = 1;
        wrb = 1;
        @(negedge clk);
        csb   = 0;
        wrb   = !wr;
        ca    = 8'(idx * 2);
        cd_in = d;
        @(negedge clk);
        csb = 1;
        wrb = 1;
    endtask

    initial begin
        int n;
        int idx;
        bit wr;
        logic [15:0] d;

        reset = 1; csb = 1; wrb = 1; ca = 0; cd_in = 0;
        grant = 0; dout = 0;
        repeat (2) @(negedge clk);
        chk("rst_apply", {31'h0, apply}, 32'h0);
        rd("rst_cdout_26", 26, 16'h2710);
        reset = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++) begin
            m[i] = dflt(i);
            rd($sformatf("dflt_%0d", i), i, m[i]);
        end
        rd("dflt_40", 40, 16'h0000);

        // random register traffic against the model, handshake index excluded
        for (int k = 0; k < 60; k++) begin
            idx = int'($urandom_range(0, 63));
            if (idx == 29) idx = 28;
            wr = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            do_acc(wr, idx, d);
            if (wr && idx < N && idx != 10 && idx != 17 &&
                !(idx >= 29 && idx <= 32)) m[idx] = d;
            chk("rnd_tx", {31'h0, tx_prom_wr}, {31'h0, wr && idx == 10});
            chk("rnd_rx", {31'h0, rx_prom_wr}, {31'h0, wr && idx == 17});
            rd("rnd_rd", idx, (idx < N) ? m[idx] : 16'h0000);
        end
        for (int i = 0; i < N; i++) mpack[16*i +: 16] = m[i];
        checks++;
        assert (cfg_q === mpack) else begin
            errors++;
            $error("FAIL rnd_cfg observed=%h expected=%h", cfg_q, mpack);
        end

        // single write per csb-low period
        @(negedge clk);
        csb = 0; wrb = 0; ca = 8'd8; cd_in = 16'h0033;
        @(negedge clk);
        chk("wr4_first", {16'h0, cfg_q[79:64]}, 32'h0033);
        cd_in = 16'h0077;
        repeat (4) @(negedge clk);
        chk("wr4_once", {16'h0, cfg_q[79:64]}, 32'h0033);
        csb = 1; wrb = 1;
        do_acc(1, 30, 16'h1234);
        rd("ro30", 30, 16'h0000);

        do_acc(1, 10, 16'h0001);
        chk("tx_pulse", {31'h0, tx_prom_wr}, 32'h1);
        chk("rx_quiet", {31'h0, rx_prom_wr}, 32'h0);
        @(negedge clk);
        chk("tx_one_cyc", {31'h0, tx_prom_wr}, 32'h0);
        rd("rd10", 10, 16'h0000);
        do_acc(1, 17, 16'hffff);
        chk("rx_pulse", {31'h0, rx_prom_wr}, 32'h1);
        chk("tx_quiet", {31'h0, tx_prom_wr}, 32'h0);

        // statistics read with grant
        do_acc(1, 29, 16'h0001);
        chk("apply_rise", {31'h0, apply}, 32'h1);
        rd("rd29_apply", 29, 16'h0001);
        repeat (2) @(negedge clk);
        chk("apply_hold", {31'h0, apply}, 32'h1);
        grant = 1; dout = 32'ha5a5_1234;
        @(negedge clk);
        grant = 0;
        chk("apply_fall", {31'h0, apply}, 32'h0);
        rd("st30_ok", 30, 16'h0001);
        rd("st31", 31, 16'h1234);
        rd("st32", 32, 16'ha5a5);
        do_acc(0, 32, 16'h0);
        rd("st30_clr", 30, 16'h0000);

        // timeout
        do_acc(1, 29, 16'h0001);
        n = 0;
        while (apply && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_len", n, 256);
        rd("tmo30", 30, 16'h0002);
        rd("tmo31", 31, 16'hffff);
        rd("tmo32", 32, 16'hffff);

        // host abort
        do_acc(1, 29, 16'h0001);
        repeat (9) @(negedge clk);
        chk("abort_pre", {31'h0, apply}, 32'h1);
        do_acc(1, 29, 16'h0000);
        chk("abort_fall", {31'h0, apply}, 32'h0);
        rd("abort30", 30, 16'h0002);

        // grant and abort write on the same edge: grant wins
        do_acc(1, 29, 16'h0001);
        @(negedge clk);
        csb = 0; wrb = 0; ca = 8'd58; cd_in = 16'h0000;
        grant = 1; dout = 32'h0bad_f00d;
        @(negedge clk);
        csb = 1; wrb = 1; grant = 0;
        chk("race_apply", {31'h0, apply}, 32'h0);
        rd("race30", 30, 16'h0001);
        rd("race31", 31, 16'hf00d);
        rd("race32", 32, 16'h0bad);
        do_acc(0, 32, 16'h0);
        rd("race30_clr", 30, 16'h0000);

        // reset in the middle of a handshake
        do_acc(1, 29, 16'h0001);
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1 chk("rst_mid_apply", {31'h0, apply}, 32'h0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        rd("rst_29", 29, 16'h0000);
        rd("rst_30", 30, 16'h0000);
        rd("rst_4", 4, 16'h001e);
        rd("rst_31", 31, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
